// File: rtl/uart_msg_tx_if.sv
// Message handshake between the sequencer (master) and the UART message
// transmitter (slave): start request, packed message, serial line and status.
interface uart_msg_tx_if #(
    parameter int NUM_BYTES = 8
);
    logic                   transmit;
    logic [8*NUM_BYTES-1:0] str;
    logic                   tx;
    logic                   busy;
    logic                   done;

    modport master (output transmit, output str, input tx, input busy, input done);
    modport slave  (input transmit, input str, output tx, output busy, output done);
endinterface

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: serialises a fixed-length packed ASCII message as 8N1 frames,
// character 0 (most significant byte of str) first, then pulses done.
// Optional build macro UART_HASH_STOP_EN: the message ends after the stop bit
// of the first '#' character (terminator included).
//
// state | meaning
// IDLE  | line high, waiting for transmit
// START | start bit (line low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (line high), then next character or end of message
module uart_msg_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_msg_tx_if.slave   bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int SW = 8 * NUM_BYTES;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    bit_q, bit_n;
    logic [BW-1:0] byte_q, byte_n;
    logic [SW-1:0] sh_q, sh_n;
    logic          tx_q, tx_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;

    logic [7:0]    cur;
    logic          cnt_wrap;
    logic          is_last;

    // Current character always sits in the top byte of the shift register.
    assign cur      = sh_q[SW-1 -: 8];
    assign cnt_wrap = (cnt_q == CNT_LAST);
`ifdef UART_HASH_STOP_EN
    assign is_last  = (byte_q == BYTE_LAST) || (cur == 8'h23);
`else
    assign is_last  = (byte_q == BYTE_LAST);
`endif

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // State and all registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            sh_q    <= sh_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next state and next output values; tx is computed one cycle ahead so the
    // line changes on the same edge as the state it belongs to.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        sh_n    = sh_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (bus.transmit) begin
                    sh_n    = bus.str;
                    byte_n  = '0;
                    cnt_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt_wrap) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    tx_n    = cur[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_wrap) begin
                    cnt_n = '0;
                    if (bit_q == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                        tx_n  = cur[bit_q + 3'd1];
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_wrap) begin
                    cnt_n = '0;
                    if (is_last) begin
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        byte_n  = byte_q + BW'(1);
                        sh_n    = sh_q << 8;
                        tx_n    = 1'b0;
                        state_n = START;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: cycle-level behavioural model of the line, a UART
// receiver that decodes tx back into bytes, and literal timing expectations.
module tb_uart_msg_tx;
    localparam int C  = 4;
    localparam int NB = 8;
    localparam int C2 = 434;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_msg_tx_if #(.NUM_BYTES(NB)) bus ();
    uart_msg_tx_if #(.NUM_BYTES(NB)) bus2 ();

    uart_msg_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    uart_msg_tx #(.CLKS_PER_BIT(C2), .NUM_BYTES(NB)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of frames a message produces.
    function automatic int frames_for(input logic [63:0] m);
        for (int i = 0; i < NB; i++) begin
`ifdef UART_HASH_STOP_EN
            if (m[8*(NB-1-i) +: 8] == 8'h23) return i + 1;
`endif
        end
        return NB;
    endfunction

    function automatic logic [7:0] char_at(input logic [63:0] m, input int i);
        return m[8*(NB-1-i) +: 8];
    endfunction

    // Line level t cycles after the accepting edge (t < 10*C*frames).
    function automatic logic line_at(input logic [63:0] m, input int t);
        int f, p;
        logic [7:0] ch;
        f  = t / (10 * C);
        p  = (t % (10 * C)) / C;
        ch = char_at(m, f);
        if (p == 0) return 1'b0;
        if (p <= 8) return ch[p-1];
        return 1'b1;
    endfunction

    // Behavioural model: expected outputs after each edge.
    int mcyc = 0, t0 = 0, nfr_m = 0;
    logic [63:0] mmsg;
    bit active = 0;
    logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 0; exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            mcyc++;
            if (!exp_busy && bus.transmit === 1'b1) begin
                active = 1; t0 = mcyc; mmsg = bus.str; nfr_m = frames_for(bus.str);
            end
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
            if (active) begin
                if (mcyc - t0 < 10 * C * nfr_m) begin
                    exp_busy = 1'b1;
                    exp_tx   = line_at(mmsg, mcyc - t0);
                end else begin
                    exp_done = 1'b1;
                    active   = 0;
                end
            end
        end
    end

    // Compare every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("tx", bus.tx, exp_tx);
            check("busy", bus.busy, exp_busy);
            check("done", bus.done, exp_done);
        end
    end

    // Independent UART receiver: mid-bit sampling from the detected start edge.
    logic [7:0] rxq[$];
    int dph = -1;
    logic prev_tx = 1'b1;
    logic [7:0] dsh;
    always @(negedge clk) begin
        if (!rst_n) begin
            dph = -1;
        end else if (dph < 0) begin
            if (prev_tx === 1'b1 && bus.tx === 1'b0) dph = 0;
        end else begin
            dph++;
            if (dph < 9 * C && dph % C == C / 2) dsh[dph / C - 1] = bus.tx;
            if (dph == 9 * C + C / 2) begin
                check("stop_bit", bus.tx, 1'b1);
                rxq.push_back(dsh);
                dph = -1;
            end
        end
        prev_tx = bus.tx;
    end

    task automatic send(input logic [63:0] s, output int k);
        @(negedge clk);
        bus.str = s;
        bus.transmit = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus.transmit = 1'b0;
    endtask

    task automatic wait_done(input int k, input int bound, output int dly);
        dly = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dly = cyc - k;
                break;
            end
        end
    endtask

    task automatic check_rx(input string name, input logic [63:0] m);
        int n;
        n = frames_for(m);
        check({name, "_count"}, rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++)
            check({name, "_byte"}, rxq[i], char_at(m, i));
        rxq.delete();
    endtask

    initial begin
        int k, k2, dly, seen, lowc;
        logic [63:0] s1, s2, lit;
        logic [7:0] gbi[8];
        bus.transmit = 1'b0; bus.str = '0;
        bus2.transmit = 1'b0; bus2.str = '0;
        gbi = '{8'h47, 8'h42, 8'h49, 8'h33, 8'h2D, 8'h44, 8'h2D, 8'h23};

        // Reset and idle with no stimulus.
        repeat (3) @(posedge clk);
        #1 check("reset_tx", bus.tx, 1'b1);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_tx", bus.tx, 1'b1);
        check("idle_busy", bus.busy, 1'b0);

        // "GBI3-D-#": literal byte sequence and done at k+320.
        rxq.delete();
        lit = 64'h4742_4933_2D44_2D23;
        send(lit, k);
        wait_done(k, 500, dly);
        check("gbi_done_delay", dly, 320);
        check("gbi_busy_at_done", bus.busy, 1'b0);
        check("gbi_count", rxq.size(), 8);
        for (int i = 0; i < 8 && i < rxq.size(); i++) check("gbi_byte", rxq[i], gbi[i]);
        rxq.delete();
        repeat (5) @(negedge clk);

        // transmit held high, str changed mid-message, back-to-back second message.
        s1 = {$urandom, $urandom};
        s2 = {$urandom, $urandom};
        @(negedge clk);
        bus.str = s1; bus.transmit = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        repeat (100) @(negedge clk);
        bus.str = s2;
        wait_done(k, 500, dly);
        check("held_done_delay", dly, 10 * C * frames_for(s1));
        check_rx("held_first", s1);
        @(posedge clk);
        #1 k2 = cyc;
        check("b2b_start_gap", k2 - k, 10 * C * frames_for(s1) + 1);
        check("b2b_tx_low", bus.tx, 1'b0);
        check("b2b_busy", bus.busy, 1'b1);
        @(negedge clk);
        bus.transmit = 1'b0;
        wait_done(k2, 500, dly);
        check("held_second_delay", dly, 10 * C * frames_for(s2));
        check_rx("held_second", s2);
        repeat (5) @(negedge clk);

        // Reset pulse mid byte 1, then a clean message.
        send(lit, k);
        while (cyc < k + 45) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rxq.delete();
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("rst_no_done", seen, 0);
        check("rst_no_frames", rxq.size(), 0);
        s1 = {$urandom, $urandom};
        send(s1, k);
        wait_done(k, 500, dly);
        check("after_rst_delay", dly, 10 * C * frames_for(s1));
        check_rx("after_rst", s1);

        // "AB#CDEFG": terminator behaviour depends on the build.
        lit = 64'h4142_2343_4445_4647;
        send(lit, k);
        wait_done(k, 500, dly);
`ifdef UART_HASH_STOP_EN
        check("hash_done_delay", dly, 120);
        check("hash_count", rxq.size(), 3);
`else
        check("hash_done_delay", dly, 320);
        check("hash_count", rxq.size(), 8);
`endif
        check_rx("hash", lit);

        // Randomized messages with random gaps and occasional '#'.
        for (int r = 0; r < 8; r++) begin
            s1 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) s1[8*$urandom_range(0, 7) +: 8] = 8'h23;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            send(s1, k);
            wait_done(k, 500, dly);
            check("rand_done_delay", dly, 10 * C * frames_for(s1));
            check_rx("rand", s1);
        end

        // Full-rate instance: bit period and message length at 434 clocks/bit.
        @(negedge clk);
        bus2.str = 64'h4742_4933_2D44_2D23;
        bus2.transmit = 1'b1;
        @(posedge clk);
        #1 k = cyc;
        @(negedge clk);
        bus2.transmit = 1'b0;
        lowc = 0;
        while (bus2.tx === 1'b0 && lowc < 1000) begin
            lowc++;
            @(negedge clk);
        end
        check("c434_start_bit", lowc, 434);
        dly = -1;
        for (int i = 0; i < 40000; i++) begin
            if (bus2.done === 1'b1) begin
                dly = cyc - k;
                break;
            end
            @(negedge clk);
        end
        check("c434_done_delay", dly, 34720);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
